// File: rtl/mesh_mon_pkg.sv
// Purpose : shared types and helpers for the mesh progress/deadlock monitor.
// Latency : n/a (types, constants and a pure index function only).
// Backpressure: n/a; the monitor only observes valid/ready, it never drives them.
package mesh_mon_pkg;

    // Router port order; the channel index is built from it.
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_S = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // Global progress FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2
    } mon_state_e;

    // Width of the mesh-wide no-handshake counter.
    localparam int IDLE_CNT_W = 16;

    // Flat channel index of port p on router (x, y).
    function automatic int chan_idx(input int x, input int y, input int p,
                                    input int mesh_x, input int ports);
        return (y * mesh_x + x) * ports + p;
    endfunction

endpackage

// File: rtl/mesh_stall_counter.sv
// Purpose : one channel's consecutive-stall counter plus its sticky stall flag.
// Latency : counter and flag are registered, updated on the edge that sees the stall.
// Backpressure: observe-only; a stall is valid_i & !ready_i, en_i low freezes state.
// Ports   : clk_i/rst_i/clr_i/en_i control, valid_i/ready_i observed pair,
//           cnt_o current count (MESH_MON_HIST_EN builds only), sticky_o flag,
//           set_o high in the cycle whose edge will newly set the flag.
module mesh_stall_counter
    import mesh_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             ready_i,
`ifdef MESH_MON_HIST_EN
    output logic [CNT_W-1:0] cnt_o,
`endif
    output logic             sticky_o,
    output logic             set_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sticky_q, sticky_d;
    logic             stall;

    always_comb begin
        stall    = valid_i & ~ready_i;
        // Saturating increment: the counter parks at all-ones.
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (en_i) begin
            if (stall) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(STALL_LIMIT)) begin
                    sticky_d = 1'b1;
                end
            end else begin
                // Handshake or no valid: the stall run is over.
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;
    assign set_o    = sticky_d & ~sticky_q;
`ifdef MESH_MON_HIST_EN
    assign cnt_o    = cnt_q;
`endif

endmodule

// File: rtl/mesh_progress_monitor.sv
// Purpose : per-channel stall and mesh-wide deadlock monitor for a MESH_X x MESH_Y router mesh.
// Latency : all outputs registered (one edge after the observed event) except stall_any_o.
// Backpressure: observe-only; en_i low freezes every counter, flag and the FSM.
// Ports   : clk_i, rst_i (sync, active high), en_i, clr_i, ch_valid_i/ch_ready_i per channel;
//           stall_sticky_o, stall_any_o, first_ch_o/first_valid_o, deadlock_o, max_stall_o.
// Option  : define MESH_MON_HIST_EN to build the max_stall_o tracker; otherwise it is tied to 0.
module mesh_progress_monitor
    import mesh_mon_pkg::*;
#(
    parameter int  MESH_X      = 3,
    parameter int  MESH_Y      = 3,
    parameter int  PORTS       = 5,
    parameter int  CNT_W       = 8,
    parameter int  STALL_LIMIT = 64,
    parameter int  IDLE_LIMIT  = 128,
    localparam int NCH         = MESH_X * MESH_Y * PORTS,
    localparam int FIRST_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [NCH-1:0]     ch_valid_i,
    input  logic [NCH-1:0]     ch_ready_i,
    output logic [NCH-1:0]     stall_sticky_o,
    output logic               stall_any_o,
    output logic [FIRST_W-1:0] first_ch_o,
    output logic               first_valid_o,
    output logic               deadlock_o,
    output logic [CNT_W-1:0]   max_stall_o
);

    logic [NCH-1:0] sticky;
    logic [NCH-1:0] set_vec;
`ifdef MESH_MON_HIST_EN
    logic [CNT_W-1:0] cnt_arr [NCH];
`endif

    for (genvar gy = 0; gy < MESH_Y; gy++) begin : g_y
        for (genvar gx = 0; gx < MESH_X; gx++) begin : g_x
            for (genvar gp = 0; gp < PORTS; gp++) begin : g_p
                localparam int C = chan_idx(gx, gy, gp, MESH_X, PORTS);
                mesh_stall_counter #(
                    .CNT_W       (CNT_W),
                    .STALL_LIMIT (STALL_LIMIT)
                ) u_cnt (
                    .clk_i    (clk_i),
                    .rst_i    (rst_i),
                    .clr_i    (clr_i),
                    .en_i     (en_i),
                    .valid_i  (ch_valid_i[C]),
                    .ready_i  (ch_ready_i[C]),
`ifdef MESH_MON_HIST_EN
                    .cnt_o    (cnt_arr[C]),
`endif
                    .sticky_o (sticky[C]),
                    .set_o    (set_vec[C])
                );
            end
        end
    end

    assign stall_sticky_o = sticky;
    assign stall_any_o    = |sticky;

    // Lowest-index priority encoder over the channels that newly set this edge.
    logic               first_hit;
    logic [FIRST_W-1:0] first_idx;
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (set_vec[i]) begin
                first_hit = 1'b1;
                first_idx = FIRST_W'(i);
            end
        end
    end

    logic [FIRST_W-1:0] first_ch_q;
    logic               first_valid_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            first_ch_q    <= '0;
            first_valid_q <= 1'b0;
        end else if (en_i && !first_valid_q && first_hit) begin
            first_ch_q    <= first_idx;
            first_valid_q <= 1'b1;
        end
    end
    assign first_ch_o    = first_ch_q;
    assign first_valid_o = first_valid_q;

    // Global progress FSM with the mesh-wide no-handshake counter.
    mon_state_e            state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_q, idle_d;
    logic                  any_valid, any_hs;

    always_comb begin
        any_valid = |ch_valid_i;
        any_hs    = |(ch_valid_i & ch_ready_i);
        state_d   = state_q;
        idle_d    = idle_q;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    idle_d = '0;
                    if (any_valid) state_d = WATCH;
                end
                WATCH: begin
                    if (any_hs) begin
                        idle_d = '0;
                    end else if (any_valid) begin
                        idle_d = idle_q + 1'b1;
                        if (idle_d >= IDLE_CNT_W'(IDLE_LIMIT)) state_d = DEADLOCK;
                    end else begin
                        idle_d  = '0;
                        state_d = IDLE;
                    end
                end
                DEADLOCK: begin
                    // Terminal until clr/rst; progress after the fact does not clear it.
                end
                default: begin
                    state_d = IDLE;
                    idle_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= IDLE;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end
    assign deadlock_o = (state_q == DEADLOCK);

`ifdef MESH_MON_HIST_EN
    // Tracks the registered counters, so it trails them by one edge.
    logic [CNT_W-1:0] cnt_max, max_q;
    always_comb begin
        cnt_max = max_q;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_arr[i] > cnt_max) cnt_max = cnt_arr[i];
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            max_q <= '0;
        end else if (en_i) begin
            max_q <= cnt_max;
        end
    end
    assign max_stall_o = max_q;
`else
    assign max_stall_o = '0;
`endif

endmodule

// File: tb/tb_mesh_progress_monitor.sv
// Purpose : self-checking bench for mesh_progress_monitor with an expectation queue.
// Latency : expectations are queued when stimulus is applied and drained after the edge.
// Backpressure: n/a; the bench drives valid/ready patterns directly.
module tb_mesh_progress_monitor;
    import mesh_mon_pkg::*;

    localparam int MX = 3, MY = 3, NP = 5, CW = 8, SL = 64, IL = 128;
    localparam int NCH = MX * MY * NP;
    localparam int FW  = $clog2(NCH);

    localparam int K_STICKY = 0, K_ANY = 1, K_FIRST = 2, K_FVALID = 3;
    localparam int K_DL = 4, K_MAX = 5, K_VEC = 6, K_SAWDL = 7;

    logic           clk_i = 1'b0;
    logic           rst_i, en_i, clr_i;
    logic [NCH-1:0] ch_valid_i, ch_ready_i;
    logic [NCH-1:0] stall_sticky_o;
    logic           stall_any_o, first_valid_o, deadlock_o;
    logic [FW-1:0]  first_ch_o;
    logic [CW-1:0]  max_stall_o;

    int total = 0;
    int bad   = 0;
    logic saw_dl;

    string       sb_tag  [$];
    int          sb_kind [$];
    int          sb_arg  [$];
    logic [31:0] sb_exp  [$];

    always #5 clk_i = ~clk_i;

    mesh_progress_monitor #(
        .MESH_X(MX), .MESH_Y(MY), .PORTS(NP), .CNT_W(CW),
        .STALL_LIMIT(SL), .IDLE_LIMIT(IL)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .clr_i          (clr_i),
        .ch_valid_i     (ch_valid_i),
        .ch_ready_i     (ch_ready_i),
        .stall_sticky_o (stall_sticky_o),
        .stall_any_o    (stall_any_o),
        .first_ch_o     (first_ch_o),
        .first_valid_o  (first_valid_o),
        .deadlock_o     (deadlock_o),
        .max_stall_o    (max_stall_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int kind, input int arg, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_arg.push_back(arg);
        sb_exp.push_back(exp);
    endtask

    function automatic logic [31:0] observe(input int kind, input int arg);
        case (kind)
            K_STICKY: return 32'(stall_sticky_o[arg]);
            K_ANY:    return 32'(stall_any_o);
            K_FIRST:  return 32'(first_ch_o);
            K_FVALID: return 32'(first_valid_o);
            K_DL:     return 32'(deadlock_o);
            K_MAX:    return 32'(max_stall_o);
            K_VEC:    return 32'(|stall_sticky_o);
            K_SAWDL:  return 32'(saw_dl);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic sb_drain();
        while (sb_kind.size() > 0) begin
            string       t;
            int          k, a;
            logic [31:0] e;
            t = sb_tag.pop_front();
            k = sb_kind.pop_front();
            a = sb_arg.pop_front();
            e = sb_exp.pop_front();
            check_val(t, observe(k, a), e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
    endtask

    task automatic expect_all_zero(input string pfx);
        expect_out({pfx, "_vec"},    K_VEC,    0, 0);
        expect_out({pfx, "_any"},    K_ANY,    0, 0);
        expect_out({pfx, "_first"},  K_FIRST,  0, 0);
        expect_out({pfx, "_fvalid"}, K_FVALID, 0, 0);
        expect_out({pfx, "_dl"},     K_DL,     0, 0);
        expect_out({pfx, "_max"},    K_MAX,    0, 0);
    endtask

    initial begin
        int c0, c3, c7, c5, c2, c10;
        int exp_max;
        c0  = chan_idx(0, 0, int'(PORT_N), MX, NP);
        c3  = chan_idx(0, 0, int'(PORT_W), MX, NP);
        c7  = chan_idx(1, 0, int'(PORT_S), MX, NP);
        c5  = chan_idx(1, 0, int'(PORT_N), MX, NP);
        c2  = chan_idx(0, 0, int'(PORT_S), MX, NP);
        c10 = chan_idx(2, 0, int'(PORT_N), MX, NP);

        rst_i = 1'b1; en_i = 1'b1; clr_i = 1'b0;
        ch_valid_i = '0; ch_ready_i = '0; saw_dl = 1'b0;
        tick(2);
        rst_i = 1'b0;
        expect_all_zero("reset");
        sb_drain();

        // Single channel stalled from the first edge.
        ch_valid_i[c0] = 1'b1;
        tick(63);
        expect_out("s1_sticky_e63", K_STICKY, c0, 0);
        expect_out("s1_any_e63",    K_ANY,    0,  0);
        sb_drain();
        tick(1);
        expect_out("s1_sticky_e64", K_STICKY, c0, 1);
        expect_out("s1_any_e64",    K_ANY,    0,  1);
        expect_out("s1_first",      K_FIRST,  0,  c0);
        expect_out("s1_fvalid",     K_FVALID, 0,  1);
        expect_out("s1_dl_e64",     K_DL,     0,  0);
        sb_drain();
        tick(64);
        expect_out("s1_dl_e128", K_DL, 0, 0);
        sb_drain();
        tick(1);
        expect_out("s1_dl_e129", K_DL, 0, 1);
`ifdef MESH_MON_HIST_EN
        exp_max = 128;
`else
        exp_max = 0;
`endif
        expect_out("s1_max", K_MAX, 0, exp_max);
        sb_drain();

        // clr while deadlocked and still stalling; counting restarts after.
        pulse_clr();
        expect_all_zero("clr");
        sb_drain();
        tick(63);
        expect_out("clr_restart_e63", K_STICKY, c0, 0);
        sb_drain();
        tick(1);
        expect_out("clr_restart_e64", K_STICKY, c0, 1);
        sb_drain();

        // Two channels start together: lowest index is reported.
        ch_valid_i = '0;
        pulse_clr();
        ch_valid_i[c7] = 1'b1;
        ch_valid_i[c3] = 1'b1;
        tick(63);
        expect_out("s2_fvalid_e63", K_FVALID, 0, 0);
        sb_drain();
        tick(1);
        expect_out("s2_sticky7", K_STICKY, c7, 1);
        expect_out("s2_sticky3", K_STICKY, c3, 1);
        expect_out("s2_first",   K_FIRST,  0,  c3);
        expect_out("s2_fvalid",  K_FVALID, 0,  1);
        sb_drain();

        // Handshake on the edge that would reach the limit wins.
        ch_valid_i = '0;
        pulse_clr();
        ch_valid_i[c5] = 1'b1;
        tick(63);
        ch_ready_i[c5] = 1'b1;
        tick(1);
        expect_out("s3_sticky5", K_STICKY, c5, 0);
        expect_out("s3_any",     K_ANY,    0,  0);
`ifdef MESH_MON_HIST_EN
        exp_max = 63;
`else
        exp_max = 0;
`endif
        expect_out("s3_max", K_MAX, 0, exp_max);
        sb_drain();
        ch_ready_i = '0;
        ch_valid_i = '0;
        tick(2);
        expect_out("s3_sticky5_later", K_STICKY, c5, 0);
        sb_drain();

        // en low mid-stall freezes counters; limit is reached 24 edges after re-enable.
        pulse_clr();
        ch_valid_i[c2] = 1'b1;
        tick(40);
        en_i = 1'b0;
        tick(20);
        expect_out("s5_sticky_en0", K_STICKY, c2, 0);
        sb_drain();
        en_i = 1'b1;
        tick(23);
        expect_out("s5_sticky_e23", K_STICKY, c2, 0);
        sb_drain();
        tick(1);
        expect_out("s5_sticky_e24", K_STICKY, c2, 1);
        sb_drain();

        // All channels valid, one handshake every 100 cycles: never deadlocks.
        ch_valid_i = '0;
        pulse_clr();
        ch_valid_i = '1;
        saw_dl = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            ch_ready_i = '0;
            if (cyc % 100 == 99) ch_ready_i[c10] = 1'b1;
            tick(1);
            if (deadlock_o) saw_dl = 1'b1;
        end
        expect_out("s4_no_deadlock", K_SAWDL, 0, 0);
        expect_out("s4_first",       K_FIRST, 0, 0);
        expect_out("s4_all_sticky",  K_STICKY, NCH - 1, 1);
`ifdef MESH_MON_HIST_EN
        exp_max = 255;
`else
        exp_max = 0;
`endif
        expect_out("s4_max_sat", K_MAX, 0, exp_max);
        sb_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
